// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared states, status codes and frame slices for the DHT11 scheduler
package dht11_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_RESULT
    } state_e;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_CHECKSUM = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;
    localparam logic [1:0] STATUS_SENSOR   = 2'd3;

    localparam int FRAME_W     = 40;
    localparam int HUM_INT_MSB  = 39;
    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_MSB  = 31;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_MSB = 23;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_MSB = 15;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CHK_MSB      = 7;
    localparam int CHK_LSB      = 0;

endpackage

// File: rtl/dht11_checksum.sv
// rtl/dht11_checksum.sv - combinational checksum test of a 40-bit DHT11 frame
module dht11_checksum
    import dht11_pkg::*;
(
    input  logic [FRAME_W-1:0] frame,
    output logic               chk_ok
);

    logic [7:0] sum;

    // Byte sum wraps modulo 256 by keeping the result 8 bits wide.
    always_comb begin
        sum = frame[HUM_INT_MSB:HUM_INT_LSB]
            + frame[HUM_DEC_MSB:HUM_DEC_LSB]
            + frame[TEMP_INT_MSB:TEMP_INT_LSB]
            + frame[TEMP_DEC_MSB:TEMP_DEC_LSB];
        chk_ok = (sum == frame[CHK_MSB:CHK_LSB]);
    end

endmodule

// File: rtl/dht11_read_scheduler.sv
// rtl/dht11_read_scheduler.sv - releases the DHT11 reader per request, enforces interval, timeout and retry
module dht11_read_scheduler
    import dht11_pkg::*;
#(
    parameter int MIN_INTERVAL_CYC = 100_000_000,
    parameter int TIMEOUT_CYC      = 5_000_000,
    parameter int MAX_RETRY        = 2
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic               req,
    output logic               busy,
    output logic               valid,
    output logic [7:0]         hum_int,
    output logic [7:0]         hum_dec,
    output logic [7:0]         temp_int,
    output logic [7:0]         temp_dec,
    output logic [1:0]         status,
    output logic [1:0]         retries,
    output logic               sensor_rst,
    input  logic               sensor_done,
    input  logic               sensor_error,
    input  logic [FRAME_W-1:0] sensor_data
);

    localparam int INT_W = $clog2(MIN_INTERVAL_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [INT_W-1:0] INT_MAX   = INT_W'(MIN_INTERVAL_CYC);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [INT_W-1:0]   int_cnt_q, int_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [1:0]         retry_q, retry_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [1:0]         res_status_q, res_status_d;
    logic [7:0]         hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]         temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;
    logic [1:0]         status_q, status_d, retries_q, retries_d;

    logic       ready;
    logic       chk_ok;
    logic       fail;
    logic [1:0] fail_status;

    dht11_checksum u_checksum (
        .frame  (frame_q),
        .chk_ok (chk_ok)
    );

    assign ready = (int_cnt_q == INT_MAX);

    always_comb begin
        state_d      = state_q;
        int_cnt_d    = ready ? int_cnt_q : int_cnt_q + 1'b1;
        to_cnt_d     = '0;
        retry_d      = retry_q;
        frame_d      = frame_q;
        res_status_d = res_status_q;
        hum_int_d    = hum_int_q;
        hum_dec_d    = hum_dec_q;
        temp_int_d   = temp_int_q;
        temp_dec_d   = temp_dec_q;
        status_d     = status_q;
        retries_d    = retries_q;
        fail         = 1'b0;
        fail_status  = STATUS_OK;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    retry_d = '0;
                    state_d = ready ? ST_WAIT_DONE : ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A done in the final timeout cycle still wins.
                if (sensor_done) begin
                    frame_d = sensor_data;
                    if (sensor_error) begin
                        fail        = 1'b1;
                        fail_status = STATUS_SENSOR;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    frame_d     = '0;
                    fail        = 1'b1;
                    fail_status = STATUS_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (chk_ok) begin
                    res_status_d = STATUS_OK;
                    state_d      = ST_RESULT;
                end else begin
                    fail        = 1'b1;
                    fail_status = STATUS_CHECKSUM;
                end
            end
            ST_RESULT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (fail) begin
            res_status_d = fail_status;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_HOLDOFF;
            end else begin
                state_d = ST_RESULT;
            end
        end

        // Each release restarts the interval so retries honour it too.
        if (state_d == ST_WAIT_DONE && state_q != ST_WAIT_DONE) int_cnt_d = '0;

        if (state_d == ST_RESULT && state_q != ST_RESULT) begin
            hum_int_d  = frame_d[HUM_INT_MSB:HUM_INT_LSB];
            hum_dec_d  = frame_d[HUM_DEC_MSB:HUM_DEC_LSB];
            temp_int_d = frame_d[TEMP_INT_MSB:TEMP_INT_LSB];
            temp_dec_d = frame_d[TEMP_DEC_MSB:TEMP_DEC_LSB];
            status_d   = res_status_d;
            retries_d  = retry_d;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            int_cnt_q    <= '0;
            to_cnt_q     <= '0;
            retry_q      <= '0;
            frame_q      <= '0;
            res_status_q <= STATUS_OK;
            hum_int_q    <= '0;
            hum_dec_q    <= '0;
            temp_int_q   <= '0;
            temp_dec_q   <= '0;
            status_q     <= STATUS_OK;
            retries_q    <= '0;
        end else begin
            state_q      <= state_d;
            int_cnt_q    <= int_cnt_d;
            to_cnt_q     <= to_cnt_d;
            retry_q      <= retry_d;
            frame_q      <= frame_d;
            res_status_q <= res_status_d;
            hum_int_q    <= hum_int_d;
            hum_dec_q    <= hum_dec_d;
            temp_int_q   <= temp_int_d;
            temp_dec_q   <= temp_dec_d;
            status_q     <= status_d;
            retries_q    <= retries_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign valid      = (state_q == ST_RESULT);
    assign sensor_rst = (state_q != ST_WAIT_DONE);
    assign hum_int    = hum_int_q;
    assign hum_dec    = hum_dec_q;
    assign temp_int   = temp_int_q;
    assign temp_dec   = temp_dec_q;
    assign status     = status_q;
    assign retries    = retries_q;

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// tb/tb_dht11_read_scheduler.sv - directed self-checking bench with a behavioural DHT11 reader model
module tb_dht11_read_scheduler;

    localparam int RESP_DLY = 20;
    localparam logic [39:0] GOOD_FRAME = 40'h2800_1A00_42;
    localparam logic [39:0] BAD_FRAME  = 40'h2800_1A00_00;

    logic        clk_50MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        busy, valid, sensor_rst;
    logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
    logic [1:0]  status, retries;
    logic        sensor_done = 1'b0;
    logic        sensor_error = 1'b0;
    logic [39:0] sensor_data = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int c0 = 0;
    int mode = 0;
    logic mon_clr = 1'b1;

    int att, dly;
    logic rst_prev_m;
    int rel_cnt, valid_cnt, done_cyc, valid_cyc;
    int rel_cyc [8];
    int low_len [8];
    logic rst_prev;
    logic [7:0] cap_hum_int, cap_hum_dec, cap_temp_int, cap_temp_dec;
    logic [1:0] cap_status, cap_retries;

    dht11_read_scheduler #(
        .MIN_INTERVAL_CYC (200),
        .TIMEOUT_CYC      (50),
        .MAX_RETRY        (2)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .rst_n        (rst_n),
        .req          (req),
        .busy         (busy),
        .valid        (valid),
        .hum_int      (hum_int),
        .hum_dec      (hum_dec),
        .temp_int     (temp_int),
        .temp_dec     (temp_dec),
        .status       (status),
        .retries      (retries),
        .sensor_rst   (sensor_rst),
        .sensor_done  (sensor_done),
        .sensor_error (sensor_error),
        .sensor_data  (sensor_data)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Reader model: mode 0 good, 1 bad checksum, 2 silent, 3 error then good.
    always @(posedge clk_50MHz) begin
        rst_prev_m <= sensor_rst;
        if (mon_clr) att <= 0;
        else if (sensor_rst && !rst_prev_m) att <= att + 1;
        if (sensor_rst) begin
            sensor_done  <= 1'b0;
            sensor_error <= 1'b0;
            sensor_data  <= '0;
            dly          <= 0;
        end else begin
            if (dly <= RESP_DLY) dly <= dly + 1;
            if (dly == RESP_DLY && mode != 2) begin
                sensor_done <= 1'b1;
                if (mode == 1) begin
                    sensor_data <= BAD_FRAME;
                end else if (mode == 3 && att == 0) begin
                    sensor_error <= 1'b1;
                    sensor_data  <= '1;
                end else begin
                    sensor_data <= GOOD_FRAME;
                end
            end
        end
    end

    always @(negedge clk_50MHz) begin
        rst_prev <= sensor_rst;
        if (mon_clr) begin
            rel_cnt   <= 0;
            valid_cnt <= 0;
            done_cyc  <= 0;
            valid_cyc <= 0;
            rst_prev  <= 1'b1;
        end else begin
            if (!sensor_rst && rel_cnt < 8) begin
                if (rst_prev) begin
                    rel_cyc[rel_cnt] <= cyc;
                    low_len[rel_cnt] <= 1;
                    rel_cnt          <= rel_cnt + 1;
                end else if (rel_cnt > 0) begin
                    low_len[rel_cnt-1] <= low_len[rel_cnt-1] + 1;
                end
            end
            if (sensor_done && !sensor_rst && done_cyc == 0) done_cyc <= cyc;
            if (valid) begin
                valid_cnt    <= valid_cnt + 1;
                valid_cyc    <= cyc;
                cap_hum_int  <= hum_int;
                cap_hum_dec  <= hum_dec;
                cap_temp_int <= temp_int;
                cap_temp_dec <= temp_dec;
                cap_status   <= status;
                cap_retries  <= retries;
            end
        end
    end

    task automatic do_reset();
        req = 1'b0;
        mon_clr = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        rst_n = 1'b1;
        c0 = cyc;
        #1 mon_clr = 1'b0;
    endtask

    task automatic wait_valid(input int n, input int budget);
        for (int i = 0; i < budget && valid_cnt < n; i++) begin
            @(negedge clk_50MHz);
            #1;
        end
    endtask

    task automatic pulse_req(input int delay);
        repeat (delay) @(negedge clk_50MHz);
        req = 1'b1;
        @(negedge clk_50MHz);
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total += 7;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        if (sensor_rst !== 1'b1) begin bad++; $display("FAIL reset_sensor_rst got=%b want=1", sensor_rst); end
        if (status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d want=0", status); end
        if (retries !== 2'd0) begin bad++; $display("FAIL reset_retries got=%0d want=0", retries); end
        if ({hum_int, hum_dec} !== 16'h0) begin bad++; $display("FAIL reset_hum got=%h want=0000", {hum_int, hum_dec}); end
        if ({temp_int, temp_dec} !== 16'h0) begin bad++; $display("FAIL reset_temp got=%h want=0000", {temp_int, temp_dec}); end
        do_reset();
    endtask

    task automatic test_good_frame();
        mode = 0;
        do_reset();
        repeat (300) @(negedge clk_50MHz);
        req = 1'b1;
        @(negedge clk_50MHz);
        req = 1'b0;
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL good_busy_rise got=%b want=1", busy); end
        if (sensor_rst !== 1'b0) begin bad++; $display("FAIL good_release got=%b want=0", sensor_rst); end
        wait_valid(1, 500);
        total += 8;
        if (valid_cnt !== 1) begin bad++; $display("FAIL good_valid_cnt got=%0d want=1", valid_cnt); end
        if (cap_hum_int !== 8'h28) begin bad++; $display("FAIL good_hum_int got=%h want=28", cap_hum_int); end
        if (cap_hum_dec !== 8'h00) begin bad++; $display("FAIL good_hum_dec got=%h want=00", cap_hum_dec); end
        if (cap_temp_int !== 8'h1A) begin bad++; $display("FAIL good_temp_int got=%h want=1a", cap_temp_int); end
        if (cap_status !== 2'd0) begin bad++; $display("FAIL good_status got=%0d want=0", cap_status); end
        if (cap_retries !== 2'd0) begin bad++; $display("FAIL good_retries got=%0d want=0", cap_retries); end
        if (valid_cyc - done_cyc !== 2) begin bad++; $display("FAIL good_done_to_valid got=%0d want=2", valid_cyc - done_cyc); end
        if (rel_cnt !== 1) begin bad++; $display("FAIL good_releases got=%0d want=1", rel_cnt); end
        @(negedge clk_50MHz);
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_fall got=%b want=0", busy); end
        if (valid !== 1'b0) begin bad++; $display("FAIL good_valid_single got=%b want=0", valid); end
        repeat (10) @(negedge clk_50MHz);
        total += 1;
        if (hum_int !== 8'h28) begin bad++; $display("FAIL good_hold got=%h want=28", hum_int); end
    endtask

    task automatic test_early_req();
        mode = 0;
        do_reset();
        pulse_req(10);
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL early_busy got=%b want=1", busy); end
        if (sensor_rst !== 1'b1) begin bad++; $display("FAIL early_holdoff got=%b want=1", sensor_rst); end
        wait_valid(1, 800);
        total += 4;
        if (valid_cnt !== 1) begin bad++; $display("FAIL early_valid_cnt got=%0d want=1", valid_cnt); end
        if (rel_cnt !== 1) begin bad++; $display("FAIL early_releases got=%0d want=1", rel_cnt); end
        if (rel_cyc[0] - c0 < 200 || rel_cyc[0] - c0 > 201) begin
            bad++; $display("FAIL early_release_time got=%0d want=200..201", rel_cyc[0] - c0);
        end
        if (cap_status !== 2'd0) begin bad++; $display("FAIL early_status got=%0d want=0", cap_status); end
    endtask

    task automatic test_bad_checksum();
        mode = 1;
        do_reset();
        pulse_req(250);
        wait_valid(1, 2000);
        total += 7;
        if (valid_cnt !== 1) begin bad++; $display("FAIL badck_valid_cnt got=%0d want=1", valid_cnt); end
        if (rel_cnt !== 3) begin bad++; $display("FAIL badck_releases got=%0d want=3", rel_cnt); end
        if (rel_cyc[1] - rel_cyc[0] < 200) begin bad++; $display("FAIL badck_gap1 got=%0d want>=200", rel_cyc[1] - rel_cyc[0]); end
        if (rel_cyc[2] - rel_cyc[1] < 200) begin bad++; $display("FAIL badck_gap2 got=%0d want>=200", rel_cyc[2] - rel_cyc[1]); end
        if (cap_status !== 2'd1) begin bad++; $display("FAIL badck_status got=%0d want=1", cap_status); end
        if (cap_retries !== 2'd2) begin bad++; $display("FAIL badck_retries got=%0d want=2", cap_retries); end
        if (cap_temp_int !== 8'h1A) begin bad++; $display("FAIL badck_temp_int got=%h want=1a", cap_temp_int); end
    endtask

    task automatic test_timeout();
        mode = 2;
        do_reset();
        pulse_req(250);
        wait_valid(1, 2000);
        total += 8;
        if (valid_cnt !== 1) begin bad++; $display("FAIL tmo_valid_cnt got=%0d want=1", valid_cnt); end
        if (rel_cnt !== 3) begin bad++; $display("FAIL tmo_releases got=%0d want=3", rel_cnt); end
        if (low_len[0] !== 50) begin bad++; $display("FAIL tmo_low0 got=%0d want=50", low_len[0]); end
        if (low_len[2] !== 50) begin bad++; $display("FAIL tmo_low2 got=%0d want=50", low_len[2]); end
        if (cap_status !== 2'd2) begin bad++; $display("FAIL tmo_status got=%0d want=2", cap_status); end
        if (cap_retries !== 2'd2) begin bad++; $display("FAIL tmo_retries got=%0d want=2", cap_retries); end
        if (cap_hum_int !== 8'h00) begin bad++; $display("FAIL tmo_hum_int got=%h want=00", cap_hum_int); end
        if (cap_temp_int !== 8'h00) begin bad++; $display("FAIL tmo_temp_int got=%h want=00", cap_temp_int); end
    endtask

    task automatic test_error_then_good();
        mode = 3;
        do_reset();
        pulse_req(250);
        wait_valid(1, 2000);
        total += 5;
        if (valid_cnt !== 1) begin bad++; $display("FAIL err_valid_cnt got=%0d want=1", valid_cnt); end
        if (rel_cnt !== 2) begin bad++; $display("FAIL err_releases got=%0d want=2", rel_cnt); end
        if (cap_status !== 2'd0) begin bad++; $display("FAIL err_status got=%0d want=0", cap_status); end
        if (cap_retries !== 2'd1) begin bad++; $display("FAIL err_retries got=%0d want=1", cap_retries); end
        if (cap_hum_int !== 8'h28) begin bad++; $display("FAIL err_hum_int got=%h want=28", cap_hum_int); end
    endtask

    task automatic test_reset_mid();
        int rc;
        mode = 2;
        do_reset();
        repeat (250) @(negedge clk_50MHz);
        req = 1'b1;
        for (int i = 0; i < 50 && sensor_rst; i++) @(negedge clk_50MHz);
        repeat (10) @(negedge clk_50MHz);
        total += 1;
        if (sensor_rst !== 1'b0) begin bad++; $display("FAIL rmid_in_wait got=%b want=0", sensor_rst); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (sensor_rst !== 1'b1) begin bad++; $display("FAIL rmid_async got=%b want=1", sensor_rst); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        mode = 0;
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        c0 = cyc;
        rc = rel_cnt;
        repeat (5) @(negedge clk_50MHz);
        req = 1'b0;
        total += 1;
        if (valid_cnt !== 0) begin bad++; $display("FAIL rmid_no_valid got=%0d want=0", valid_cnt); end
        wait_valid(1, 800);
        total += 3;
        if (valid_cnt !== 1) begin bad++; $display("FAIL rmid_valid_cnt got=%0d want=1", valid_cnt); end
        if (rel_cnt !== rc + 1) begin bad++; $display("FAIL rmid_releases got=%0d want=%0d", rel_cnt, rc + 1); end
        if (rel_cyc[rc] - c0 < 200 || rel_cyc[rc] - c0 > 201) begin
            bad++; $display("FAIL rmid_release_time got=%0d want=200..201", rel_cyc[rc] - c0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_early_req();
        test_bad_checksum();
        test_timeout();
        test_error_then_good();
        test_reset_mid();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dht11_read_scheduler.md
# dht11_read_scheduler

Sequences the DHT11 reader module, which is held in reset when idle and released for exactly one transaction. It accepts read requests from the command side and enforces the sensor's minimum inter-read interval. It bounds each transaction with a timeout, verifies the checksum, and retries on failure. The decoded humidity and temperature fields and a status code are returned with a one-cycle valid strobe.

## Interface
- MIN_INTERVAL_CYC, 100_000_000: minimum cycles between consecutive reader releases (2 s at 50 MHz); also the power-up hold-off.
- TIMEOUT_CYC, 5_000_000: maximum cycles in WAIT_DONE before abort (100 ms).
- MAX_RETRY, 2: additional attempts after a failed attempt; 0 disables retry.
- clk_50MHz  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  read request, sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- valid  out  1  one-cycle strobe; result fields are valid in that cycle and held until the next strobe.
- hum_int, hum_dec, temp_int, temp_dec  out  8 each  sensor bytes data[39:32], [31:24], [23:16], [15:8].
- status  out  2  0 OK, 1 CHECKSUM, 2 TIMEOUT, 3 SENSOR (reader error flag).
- retries  out  2  number of retries consumed by the reported result.
- sensor_rst  out  1  active-high reset to the reader.
- sensor_done  in  1  reader done; stays high until the reader is reset.
- sensor_error  in  1  reader error flag.
- sensor_data  in  40  reader data bus.

## Operation
- States: IDLE, HOLDOFF, WAIT_DONE, CHECK, RESULT.
- sensor_rst = 0 only in WAIT_DONE. In all other states it is 1, which parks the reader with the line driven high.
- Interval counter:
  - Saturating at MIN_INTERVAL_CYC.
  - Cleared on every entry to WAIT_DONE.
  - Counts in all other cycles.
  - "ready" = counter == MIN_INTERVAL_CYC.
- IDLE: on req = 1, the retry count is cleared. If ready, go to WAIT_DONE; otherwise go to HOLDOFF. req = 0 stays in IDLE.
- HOLDOFF: wait for ready, then go to WAIT_DONE.
- WAIT_DONE: timeout counter is cleared on entry and increments each cycle.
  - sensor_done = 1 and sensor_error = 0: latch sensor_data, go to CHECK.
  - sensor_done = 1 and sensor_error = 1: failure with status SENSOR.
  - Timeout counter reaches TIMEOUT_CYC before done: failure with status TIMEOUT.
  - done has priority over timeout in the same cycle.
- CHECK: compare (data[39:32] + data[31:24] + data[23:16] + data[15:8]) mod 256 with data[7:0].
  - Equal: status OK, go to RESULT.
  - Not equal: failure with status CHECKSUM.
- Failure handling:
  - If retry count < MAX_RETRY: increment the retry count and go to HOLDOFF. The interval is always honoured on retry.
  - Otherwise: go to RESULT with the failure status.
- RESULT: output registers are loaded and valid = 1 for this single cycle, then go to IDLE.
  - Data fields hold the latched bytes of the last attempt.
  - A SENSOR failure reports the reader's all-ones data.
  - A TIMEOUT failure reports 0x00.
- req during busy is ignored; no queueing.

## Timing
- Reset values: busy 0, valid 0, sensor_rst 1, status 0, retries 0, all data fields 0x00, state IDLE, both counters 0.
- After reset deassertion, the first release waits the full MIN_INTERVAL_CYC, which covers the sensor power-up time.
- busy rises the cycle after req is sampled in IDLE.
- When ready is already true, sensor_rst falls the cycle after req is sampled.
- sensor_done is seen high in WAIT_DONE at cycle N: CHECK occurs at N+1, valid at N+2, busy low at N+3.
- Retry: sensor_rst returns to 1 the cycle after the failure is detected. The next release comes no earlier than MIN_INTERVAL_CYC cycles after the previous release.
- Asserting rst_n mid-transaction aborts immediately: sensor_rst goes to 1 and no valid is issued.

## Structure
- Shared package dht11_pkg holds:
  - the state enum;
  - the status codes STATUS_OK, STATUS_CHECKSUM, STATUS_TIMEOUT, STATUS_SENSOR;
  - the byte-slice constants for the 40-bit frame.
- One sub-module, dht11_checksum: a combinational 40-bit frame in, chk_ok out. It is reused by any future consumer of the frame.
- The counters and the FSM live in the top block.

## Test plan
Sim parameters: MIN_INTERVAL_CYC = 200, TIMEOUT_CYC = 50, MAX_RETRY = 2, with a behavioural reader model.
- Good frame: req at cycle 300, model returns 0x2800_1A00_42 → one valid; hum_int 0x28, temp_int 0x1A, status 0, retries 0.
- Early req at cycle 10 after reset → sensor_rst stays 1 until the interval counter reaches 200; exactly one release follows.
- Bad checksum on every attempt (0x2800_1A00_00) → three releases, each spaced ≥ 200 cycles apart; then valid with status 1, retries 2.
- Model never raises done → sensor_rst low for 50 cycles per attempt; after 3 attempts, status 2 and data fields 0x00.
- Reader error on the first attempt, good frame on the second → status 0, retries 1.
- rst_n pulsed low mid-WAIT_DONE → sensor_rst goes to 1 asynchronously; no valid is issued; req is held through the reset, so the next read waits the full interval.
